// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - Rv32H memory-access stage: single-beat bus access with byte lanes, load extension and timeout
module cpu_memory #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_memory,
  input  logic [4:0]  i_inst_rd,
  input  logic [31:0] i_rd,
  input  logic        i_branch,
  input  logic [31:0] i_pc_next,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_mem_width,
  input  logic        i_mem_signed,
  input  logic [31:0] i_mem_wdata,
  output logic        o_busy,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [3:0]  o_bus_byte_enable,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic [4:0]  o_inst_rd,
  output logic [31:0] o_rd,
  output logic        o_branch,
  output logic [31:0] o_pc_next,
  output logic        o_ready,
  output logic        o_fault
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic { IDLE = 1'b0, ACCESS = 1'b1 } state_t;

  state_t      state_q, state_d;
  logic [15:0] timeout_count;
  logic [1:0]  width_q;
  logic [1:0]  offset_q;
  logic        signed_q;
  logic        is_load_q;
  logic [4:0]  rd_index_q;

  logic        is_mem;
  logic        misaligned;
  logic        accept;
  logic        start_access;
  logic        bus_done;
  logic        bus_timeout;
  logic [3:0]  byte_enable_d;
  logic [31:0] wdata_d;
  logic [31:0] lane_data;
  logic [31:0] load_value;

  assign is_mem       = i_mem_read | i_mem_write;
  assign misaligned   = (i_mem_width == 2'd3) ||
                        (i_mem_width == 2'd1 && i_rd[0]) ||
                        (i_mem_width == 2'd2 && i_rd[1:0] != 2'b00);
  assign accept       = (state_q == IDLE) && i_memory;
  assign start_access = accept && is_mem && !misaligned;
  assign bus_done     = (state_q == ACCESS) && i_bus_ready;
  // Ready in the expiry cycle still completes normally, so timeout requires ready low.
  assign bus_timeout  = (state_q == ACCESS) && !i_bus_ready && (timeout_count == TIMEOUT_LIMIT);
  assign o_busy       = (state_q == ACCESS);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_access) state_d = ACCESS;
      ACCESS:  if (bus_done || bus_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_enable_d = 4'hF;
    wdata_d       = i_mem_wdata;
    case (i_mem_width)
      2'd0: begin
        byte_enable_d = 4'b0001 << i_rd[1:0];
        wdata_d       = {4{i_mem_wdata[7:0]}};
      end
      2'd1: begin
        byte_enable_d = 4'b0011 << i_rd[1:0];
        wdata_d       = {2{i_mem_wdata[15:0]}};
      end
      default: ;
    endcase

    lane_data = i_bus_rdata >> {offset_q, 3'b000};
    case (width_q)
      2'd0:    load_value = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                     : {24'h0, lane_data[7:0]};
      2'd1:    load_value = signed_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                     : {16'h0, lane_data[15:0]};
      default: load_value = lane_data;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      timeout_count     <= 16'h0;
      width_q           <= 2'd0;
      offset_q          <= 2'd0;
      signed_q          <= 1'b0;
      is_load_q         <= 1'b0;
      rd_index_q        <= 5'd0;
      o_bus_request     <= 1'b0;
      o_bus_rw          <= 1'b0;
      o_bus_address     <= 32'h0;
      o_bus_byte_enable <= 4'h0;
      o_bus_wdata       <= 32'h0;
      o_inst_rd         <= 5'd0;
      o_rd              <= 32'h0;
      o_branch          <= 1'b0;
      o_pc_next         <= 32'h0;
      o_ready           <= 1'b0;
      o_fault           <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      o_fault <= 1'b0;
      if (state_q == IDLE) begin
        if (!accept) begin
          o_inst_rd <= 5'd0;
        end else begin
          o_branch      <= i_branch;
          o_pc_next     <= i_pc_next;
          o_rd          <= i_rd;
          width_q       <= i_mem_width;
          offset_q      <= i_rd[1:0];
          signed_q      <= i_mem_signed;
          is_load_q     <= i_mem_read;
          rd_index_q    <= i_inst_rd;
          timeout_count <= 16'h0;
          if (!is_mem) begin
            o_inst_rd <= i_inst_rd;
            o_ready   <= 1'b1;
          end else if (misaligned) begin
            o_inst_rd <= 5'd0;
            o_ready   <= 1'b1;
            o_fault   <= 1'b1;
          end else begin
            // Read wins when both read and write are flagged.
            o_inst_rd         <= 5'd0;
            o_bus_request     <= 1'b1;
            o_bus_rw          <= !i_mem_read;
            o_bus_address     <= {i_rd[31:2], 2'b00};
            o_bus_byte_enable <= byte_enable_d;
            o_bus_wdata       <= wdata_d;
          end
        end
      end else if (bus_done) begin
        o_bus_request <= 1'b0;
        o_ready       <= 1'b1;
        if (is_load_q) begin
          o_rd      <= load_value;
          o_inst_rd <= rd_index_q;
        end else begin
          o_inst_rd <= 5'd0;
        end
      end else if (bus_timeout) begin
        o_bus_request <= 1'b0;
        o_ready       <= 1'b1;
        o_fault       <= 1'b1;
        o_inst_rd     <= 5'd0;
      end else begin
        timeout_count <= timeout_count + 16'h1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// tb/tb_cpu_memory.sv - self-checking bench for cpu_memory against a transaction-level model
module tb_cpu_memory;

  localparam int TIMEOUT = 4;

  logic        i_clock;
  logic        i_reset;
  logic        i_memory;
  logic [4:0]  i_inst_rd;
  logic [31:0] i_rd;
  logic        i_branch;
  logic [31:0] i_pc_next;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_mem_width;
  logic        i_mem_signed;
  logic [31:0] i_mem_wdata;
  logic        o_busy;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [3:0]  o_bus_byte_enable;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic [4:0]  o_inst_rd;
  logic [31:0] o_rd;
  logic        o_branch;
  logic [31:0] o_pc_next;
  logic        o_ready;
  logic        o_fault;

  cpu_memory #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_memory(i_memory),
    .i_inst_rd(i_inst_rd), .i_rd(i_rd), .i_branch(i_branch), .i_pc_next(i_pc_next),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_width(i_mem_width),
    .i_mem_signed(i_mem_signed), .i_mem_wdata(i_mem_wdata),
    .o_busy(o_busy), .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
    .o_bus_address(o_bus_address), .o_bus_byte_enable(o_bus_byte_enable),
    .o_bus_wdata(o_bus_wdata), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_inst_rd(o_inst_rd), .o_rd(o_rd), .o_branch(o_branch), .o_pc_next(o_pc_next),
    .o_ready(o_ready), .o_fault(o_fault)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    bit          never;
    bit          noise;
  } op_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] rd;
    bit          check_rd;
    logic        fault;
    logic        br;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  int   checks;
  int   failures;
  int   cycle;
  int   req_total;
  exp_t exp_q[$];

  logic        exp_bus_active;
  logic        exp_bus_rw;
  logic [31:0] exp_bus_addr;
  logic [3:0]  exp_bus_be;
  logic [31:0] exp_bus_wdata;

  logic [31:0] last_rd;
  logic [4:0]  last_inst;
  logic        last_fault;
  logic [3:0]  last_be;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic        last_rw;
  int          last_req_cycles;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic op_t mk(input logic [4:0] idx, input logic [31:0] addr, input logic rd_en,
                             input logic wr_en, input logic [1:0] width, input logic sgn,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int wait_n, input bit never, input bit noise);
    op_t o;
    o.idx = idx; o.addr = addr; o.rd_en = rd_en; o.wr_en = wr_en; o.width = width;
    o.sgn = sgn; o.wdata = wdata; o.rdata = rdata; o.wait_n = never ? TIMEOUT : wait_n;
    o.never = never; o.noise = noise;
    return o;
  endfunction

  function automatic bit bad_align(input op_t o);
    return (o.width == 2'd3) || (o.width == 2'd1 && o.addr % 2 != 0) ||
           (o.width == 2'd2 && o.addr % 4 != 0);
  endfunction

  function automatic bit uses_bus(input op_t o);
    return (o.rd_en || o.wr_en) && !bad_align(o);
  endfunction

  // Result the stage must deliver, and the sample cycle at which o_ready must be seen.
  function automatic exp_t model(input op_t o, input int c);
    exp_t    e;
    longint  span;
    longint  lane;
    e.br = o.addr[4]; e.pc = o.addr + 32'd4; e.rd = o.addr; e.check_rd = 1;
    e.idx = 5'd0; e.fault = 1'b0; e.cyc = c + 1;
    if (!o.rd_en && !o.wr_en) begin
      e.idx = o.idx;
    end else if (bad_align(o)) begin
      e.fault = 1'b1; e.check_rd = 0;
    end else begin
      e.cyc = c + 2 + o.wait_n;
      if (o.never) begin
        e.fault = 1'b1; e.check_rd = 0;
      end else if (o.rd_en) begin
        span = longint'(1) << (8 * (1 << o.width));
        lane = (longint'(o.rdata) >> (8 * (o.addr % 4))) % span;
        if (o.sgn && lane >= span / 2) lane = lane - span;
        e.rd = lane[31:0];
        e.idx = o.idx;
      end else begin
        e.check_rd = 0;
      end
    end
    return e;
  endfunction

  task automatic set_bus_exp(input op_t o);
    int nbytes;
    nbytes        = 1 << o.width;
    exp_bus_rw    = !o.rd_en;
    exp_bus_addr  = o.addr & ~32'd3;
    exp_bus_be    = 4'(((1 << nbytes) - 1) << (o.addr % 4));
    if (o.width == 2'd0)      exp_bus_wdata = {24'h0, o.wdata[7:0]} * 32'h01010101;
    else if (o.width == 2'd1) exp_bus_wdata = {16'h0, o.wdata[15:0]} * 32'h00010001;
    else                      exp_bus_wdata = o.wdata;
    exp_bus_active = 1'b1;
  endtask

  task automatic drive(input op_t o);
    i_inst_rd = o.idx; i_rd = o.addr; i_branch = o.addr[4]; i_pc_next = o.addr + 32'd4;
    i_mem_read = o.rd_en; i_mem_write = o.wr_en; i_mem_width = o.width;
    i_mem_signed = o.sgn; i_mem_wdata = o.wdata; i_memory = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge i_clock);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_bus_active = 1'b0;
  endtask

  task automatic run_op(input string name, input op_t o);
    int r0;
    r0 = req_total;
    @(negedge i_clock);
    drive(o);
    exp_q.push_back(model(o, cycle));
    if (uses_bus(o)) set_bus_exp(o);
    @(negedge i_clock);
    i_memory = 1'b0;
    if (uses_bus(o)) begin
      for (int k = 0; k < o.wait_n; k++) begin
        if (o.noise) begin
          i_memory = 1'b1; i_rd = $urandom; i_inst_rd = 5'($urandom);
          i_mem_read = 1'b0; i_mem_write = 1'b1; i_mem_width = 2'($urandom_range(0, 2));
        end
        @(negedge i_clock);
      end
      i_memory = 1'b0;
      i_bus_ready = !o.never;
      i_bus_rdata = o.rdata;
      @(negedge i_clock);
      i_bus_ready = 1'b0;
      i_bus_rdata = 32'h0;
    end
    wait_drain(name);
    last_req_cycles = req_total - r0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"}, o_bus_request, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_rw"}, o_bus_rw, 0);
    check({tag, "_address"}, o_bus_address, 0);
    check({tag, "_byte_enable"}, o_bus_byte_enable, 0);
    check({tag, "_wdata"}, o_bus_wdata, 0);
    check({tag, "_inst_rd"}, o_inst_rd, 0);
    check({tag, "_rd"}, o_rd, 0);
    check({tag, "_branch"}, o_branch, 0);
    check({tag, "_pc_next"}, o_pc_next, 0);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_fault"}, o_fault, 0);
  endtask

  always begin : compare
    exp_t e;
    @(posedge i_clock);
    #1;
    if (i_reset) begin
      check("busy_tracks_request", o_busy, o_bus_request);
      if (o_bus_request) begin
        req_total = req_total + 1;
        last_be = o_bus_byte_enable; last_addr = o_bus_address;
        last_wdata = o_bus_wdata; last_rw = o_bus_rw;
        check("request_expected", 1, exp_bus_active);
        check("bus_rw", o_bus_rw, exp_bus_rw);
        check("bus_address", o_bus_address, exp_bus_addr);
        check("bus_byte_enable", o_bus_byte_enable, exp_bus_be);
        if (exp_bus_rw) check("bus_wdata", o_bus_wdata, exp_bus_wdata);
      end
      if (o_ready) begin
        check("ready_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          last_rd = o_rd; last_inst = o_inst_rd; last_fault = o_fault;
          check("ready_cycle", cycle, e.cyc);
          check("inst_rd", o_inst_rd, e.idx);
          check("fault", o_fault, e.fault);
          check("branch", o_branch, e.br);
          check("pc_next", o_pc_next, e.pc);
          check("request_dropped", o_bus_request, 0);
          if (e.check_rd) check("rd", o_rd, e.rd);
        end
      end else begin
        check("fault_without_ready", o_fault, 0);
      end
    end
  end

  initial begin
    op_t o;
    i_reset = 1'b0; i_memory = 1'b0; i_inst_rd = 5'd0; i_rd = 32'h0; i_branch = 1'b0;
    i_pc_next = 32'h0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_width = 2'd0;
    i_mem_signed = 1'b0; i_mem_wdata = 32'h0; i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
    exp_bus_active = 1'b0; exp_bus_rw = 1'b0; exp_bus_addr = 32'h0; exp_bus_be = 4'h0;
    exp_bus_wdata = 32'h0;
    repeat (3) @(negedge i_clock);
    check_all_zero("reset");
    i_reset = 1'b1;

    run_op("alu_pass", mk(5'd5, 32'h12345678, 0, 0, 2'd2, 0, 32'h0, 32'h0, 0, 0, 0));
    check("alu_pass_rd_literal", last_rd, 32'h12345678);
    check("alu_pass_inst_literal", last_inst, 5'd5);
    check("alu_pass_no_request", last_req_cycles, 0);

    run_op("lb_signed", mk(5'd7, 32'h00001003, 1, 0, 2'd0, 1, 32'h0, 32'h80FFEE11, 3, 0, 0));
    check("lb_signed_be_literal", last_be, 4'b1000);
    check("lb_signed_addr_literal", last_addr, 32'h00001000);
    check("lb_signed_rd_literal", last_rd, 32'hFFFFFF80);
    run_op("lbu", mk(5'd7, 32'h00001003, 1, 0, 2'd0, 0, 32'h0, 32'h80FFEE11, 3, 0, 0));
    check("lbu_rd_literal", last_rd, 32'h00000080);

    run_op("sh", mk(5'd9, 32'h00002002, 0, 1, 2'd1, 0, 32'h0000BEEF, 32'h0, 1, 0, 0));
    check("sh_rw_literal", last_rw, 1);
    check("sh_be_literal", last_be, 4'b1100);
    check("sh_wdata_literal", last_wdata, 32'hBEEFBEEF);
    check("sh_inst_literal", last_inst, 5'd0);

    run_op("lw_misaligned", mk(5'd3, 32'h00003001, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 0, 0));
    check("lw_misaligned_no_request", last_req_cycles, 0);
    check("lw_misaligned_fault_literal", last_fault, 1);

    run_op("timeout", mk(5'd4, 32'h00004000, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 1, 0));
    check("timeout_request_cycles", last_req_cycles, TIMEOUT + 1);
    check("timeout_fault_literal", last_fault, 1);
    run_op("ready_at_expiry", mk(5'd4, 32'h00004000, 1, 0, 2'd2, 0, 32'h0, 32'hCAFEF00D, TIMEOUT, 0, 0));
    check("ready_at_expiry_fault_literal", last_fault, 0);
    check("ready_at_expiry_rd_literal", last_rd, 32'hCAFEF00D);

    run_op("lh_signed_hi", mk(5'd10, 32'h00004002, 1, 0, 2'd1, 1, 32'h0, 32'h80011234, 0, 0, 0));
    check("lh_signed_hi_rd_literal", last_rd, 32'hFFFF8001);
    run_op("lhu_lo", mk(5'd11, 32'h00005000, 1, 0, 2'd1, 0, 32'h0, 32'h1234ABCD, 2, 0, 0));
    run_op("lw", mk(5'd12, 32'h00005008, 1, 0, 2'd2, 1, 32'h0, 32'h89ABCDEF, 0, 0, 0));
    run_op("sb", mk(5'd13, 32'h00006001, 0, 1, 2'd0, 0, 32'h123456AB, 32'h0, 2, 0, 0));
    check("sb_be_literal", last_be, 4'b0010);
    check("sb_wdata_literal", last_wdata, 32'hABABABAB);
    run_op("sw", mk(5'd14, 32'h00006010, 0, 1, 2'd2, 0, 32'hDEADBEEF, 32'h0, 1, 0, 0));
    run_op("width3", mk(5'd15, 32'h00007000, 1, 0, 2'd3, 0, 32'h0, 32'h0, 0, 0, 0));
    run_op("sh_misaligned", mk(5'd16, 32'h00008001, 0, 1, 2'd1, 0, 32'h1111, 32'h0, 0, 0, 0));
    run_op("read_priority", mk(5'd17, 32'h00005004, 1, 1, 2'd2, 0, 32'h55555555, 32'h01020304, 1, 0, 0));
    check("read_priority_rw_literal", last_rw, 0);
    run_op("noise_during_access", mk(5'd18, 32'h0000A006, 1, 0, 2'd0, 1, 32'h0, 32'h7F00_0000, 3, 0, 1));

    // Back-to-back pass-through at full rate.
    @(negedge i_clock);
    for (int k = 0; k < 3; k++) begin
      o = mk(5'(20 + k), 32'h0000B000 + 32'(k * 16 + 1), 0, 0, 2'd2, 0, 32'h0, 32'h0, 0, 0, 0);
      drive(o);
      exp_q.push_back(model(o, cycle));
      @(negedge i_clock);
    end
    i_memory = 1'b0;
    wait_drain("back_to_back");

    // Reset asserted while a load is outstanding.
    o = mk(5'd25, 32'h00009010, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge i_clock);
    drive(o);
    set_bus_exp(o);
    @(negedge i_clock);
    i_memory = 1'b0;
    @(negedge i_clock);
    check("mid_access_request", o_bus_request, 1);
    #2;
    i_reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_bus_active = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    run_op("after_reset", mk(5'd26, 32'h00009014, 1, 0, 2'd1, 1, 32'h0, 32'hFFFE0001, 1, 0, 0));
    check("after_reset_rd_literal", last_rd, 32'h00000001);

    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Memory-access stage of the Rv32H pipeline, directly downstream of the execute stage. It captures execute results and, for loads/stores, runs a single-beat bus transaction with byte enables, load sign/zero extension and a bus timeout. Results then go to writeback as a one-cycle `o_ready` pulse. Non-memory instructions pass through with one cycle of latency.

## Interface
- TIMEOUT_CYCLES, default 255: cycles `o_bus_request` may stay high without `i_bus_ready` before a fault is raised; range 1..65535.
- i_clock  in  1  pipeline clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_memory  in  1  execute result valid this cycle (execute `o_ready`)
- i_inst_rd  in  5  destination register index
- i_rd  in  32  execute result (ALU value / effective address for load/store)
- i_branch  in  1  branch taken flag
- i_pc_next  in  32  next PC from execute
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store
- i_mem_width  in  2  0 byte, 1 half, 2 word; 3 is illegal
- i_mem_signed  in  1  sign-extend load result
- i_mem_wdata  in  32  store data (rs2)
- o_busy  out  1  stage not in IDLE; upstream must hold `i_memory` low
- o_bus_request  out  1  bus transaction active
- o_bus_rw  out  1  1 write, 0 read
- o_bus_address  out  32  word-aligned address (`i_rd` with bits [1:0] cleared)
- o_bus_byte_enable  out  4  active lanes
- o_bus_wdata  out  32  store data replicated onto the active lanes
- i_bus_ready  in  1  bus completes the transaction this cycle
- i_bus_rdata  in  32  read data, valid when `i_bus_ready` is high
- o_inst_rd  out  5  writeback register index (0 means no write)
- o_rd  out  32  writeback value
- o_branch  out  1  forwarded branch flag
- o_pc_next  out  32  forwarded next PC
- o_ready  out  1  one-cycle result strobe to writeback
- o_fault  out  1  one-cycle strobe with `o_ready` on a misaligned access, illegal width, or timeout

## Operation
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset applies immediately even mid-transaction; any outstanding bus request is dropped.
- State IDLE:
  - `i_memory` low: `o_ready`, `o_fault` and `o_inst_rd` go to 0.
  - `i_memory` high: capture `i_branch`, `i_pc_next`, `i_inst_rd`, `i_rd`, width, signedness and offset `i_rd[1:0]`.
- Non-memory op (neither read nor write): next cycle `o_rd = i_rd`, `o_ready = 1`, stay in IDLE.
- Misaligned access (half with `i_rd[0] == 1`, word with `i_rd[1:0] != 0`) or width 3: no bus request. Next cycle `o_ready = 1`, `o_fault = 1`, `o_inst_rd = 0`.
- Legal access: go to ACCESS with `o_bus_request = 1`.
  - Byte enables: byte gives `1 << off`; half gives `4'b0011 << off`; word gives `4'hF`.
  - Store: `o_bus_wdata` is the byte replicated ×4, or the half replicated ×2, or the full word.
  - A store sets `o_inst_rd = 0` at completion.
- If both read and write are set, read takes priority.
- ACCESS state:
  - Outputs are held stable.
  - Counter increments each cycle that `i_bus_ready` is low.
  - On `i_bus_ready` high: drop request, go to IDLE, pulse `o_ready`. For a load, `o_rd` is the selected lane shifted to bit 0, then zero- or sign-extended.
  - If the counter reaches TIMEOUT_CYCLES: drop request, pulse `o_ready` and `o_fault`, `o_inst_rd = 0`, go to IDLE.
  - If `i_bus_ready` and timeout occur in the same cycle, `i_bus_ready` wins.
- `i_memory` asserted while not in IDLE is ignored and does not disturb the active transaction.
- `o_busy` is high exactly while in ACCESS.

## Timing
- Pass-through: `i_memory` sampled at edge N, so `o_ready` is high for the cycle after N only.
- Load/store: `i_memory` at edge N, so `o_bus_request` rises after N. If `i_bus_ready` is first sampled high at edge M (M ≥ N+1), `o_bus_request` falls and `o_ready` pulses after M. Minimum latency is 2 cycles.
- `o_rd`, `o_inst_rd`, `o_branch` and `o_pc_next` are valid while `o_ready` is high and hold until the next capture.
- Timeout: the fault pulses after TIMEOUT_CYCLES + 1 edges of request without ready.
- A new `i_memory` is accepted at the same edge where `o_ready` is pulsed from IDLE pass-through; this allows back-to-back pass-through at full rate.

## Test plan
- Pass-through: ALU op `i_rd = 0x12345678`, rd = 5 → `o_ready` one cycle later with `o_rd = 0x12345678`, `o_inst_rd = 5`, no bus request.
- Signed byte load: address 0x1003, bus returns 0x80FFEE11 after 3 wait cycles → byte enable `4'b1000`, `o_bus_address = 0x1000`, `o_rd = 0xFFFFFF80`. Repeat unsigned → `o_rd = 0x00000080`.
- Half store: address 0x2002, data 0x0000BEEF → `o_bus_rw = 1`, byte enable `4'b1100`, `o_bus_wdata = 0xBEEFBEEF`, `o_inst_rd = 0` at completion.
- Misaligned word load at 0x3001 → no `o_bus_request`; `o_ready` and `o_fault` pulse one cycle later with `o_inst_rd = 0`.
- Timeout with TIMEOUT_CYCLES = 4 and `i_bus_ready` never high → fault pulse after the request has been high for 5 cycles. A second variant asserts `i_bus_ready` on the expiry cycle → normal completion, no fault.
- Reset asserted mid-ACCESS → all outputs 0 immediately; after release, a new load completes normally.
